adder_mux_bist: RTL and testbench
=================================

# adder_mux_bist

Synchronous built-in self-test controller for the 1-bit adder-with-operand/output-mux datapath. The controller drives all seven datapath inputs (A0, A1, B0, B1, Sa, Sb, Ss) through every one of the 128 combinations. It samples the datapath outputs S0 and S1 for each combination, compares them against an internal golden model, and reports the pass/fail result, the error count and the first failing vector. It sits beside the adder-mux block at the top level and replaces manual stimulus as the on-chip exerciser of that datapath.

## Interface
- SETTLE, default 2: idle cycles between applying a vector and sampling S0/S1; legal range 0–15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a full sweep.
- A0, A1, B0, B1, Sa, Sb, Ss  out  1 each  registered drive to the datapath under test.
- S0, S1  in  1 each  datapath outputs under test, same clock domain.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; held until the next accepted start.
- pass  out  1  done and err_count == 0.
- err_count  out  8  number of mismatching vectors, range 0–128.
- first_fail  out  7  vector index of the first mismatch; 0 if none.

## Operation
- Vector index v[6:0] maps to the drive bits as {Ss,Sb,Sa,B1,B0,A1,A0}, with bit 0 driving A0.
- Golden model:
  - a = Sa ? A1 : A0 and b = Sb ? B1 : B0.
  - s = a^b and c = a&b.
  - When Ss = 1: S0 = s and S1 = c.
  - When Ss = 0: S0 = c and S1 = s.
- A vector mismatches if either S0 or S1 differs from the model; a mismatch counts as one error per vector.
- FSM states are IDLE, APPLY, WAIT, CHECK and DONE.
  - IDLE/DONE → APPLY when start = 1. On this transition v, err_count, first_fail and done are cleared.
  - APPLY: drive registers take v; go to WAIT, or go directly to CHECK if SETTLE = 0.
  - WAIT: stay for SETTLE cycles, then go to CHECK.
  - CHECK: compare the sampled S0/S1 against the model for v.
    - On mismatch, increment err_count. If err_count was 0, capture first_fail = v.
    - If v = 127, go to DONE; otherwise increment v and go to APPLY.
  - DONE: done = 1. Stay in DONE until start.
- start is ignored while busy (APPLY, WAIT or CHECK).
- Drive outputs hold their last vector in DONE and return to 0 on reset.

## Timing
- Reset values: all drive outputs 0, busy 0, done 0, pass 0, err_count 0, first_fail 0, state IDLE.
- Reset mid-sweep aborts the sweep immediately; no partial results are retained.
- busy rises on the clock edge that samples start and falls on the edge on which done rises.
- Each vector takes SETTLE+2 cycles. done rises 128·(SETTLE+2) cycles after the edge that samples start; this is 512 cycles at the default setting.
- S0/S1 are sampled on the CHECK-state edge. At that point the inputs have been stable for SETTLE+1 cycles.
- pass is combinational from done and err_count; it is never 1 while busy.

## Structure
- Package adder_mux_pkg holds:
  - the state enum;
  - VEC_W = 7 and NUM_VEC = 128;
  - the vector-to-bit field positions.
- Sub-module adder_mux_ref is the purely combinational golden model: inputs are a 7-bit vector, outputs are expected S0/S1. It is reused by the bench scoreboard.
- Top module contains the FSM, the SETTLE counter, the vector counter and the result registers.

## Test plan
- Connect the correct adder-mux datapath and pulse start → done after 512 cycles, pass = 1, err_count = 0, first_fail = 0.
- S0 stuck-at-0 → err_count = 48, first_fail = 5, pass = 0.
- S1 stuck-at-0 → err_count = 48, first_fail = 1.
- S0/S1 swapped → err_count = 96, first_fail = 1.
- Pulse start again at cycle 100 of a sweep → pulse ignored; sweep still completes at cycle 512.
- Pull rst_n low at cycle 200, then pulse start → all outputs read 0 during reset; the fresh sweep completes in 512 cycles with correct results.

Source files
------------

// File: rtl/adder_mux_pkg.sv
// Shared types and constants for the adder-mux BIST controller and its golden model.
package adder_mux_pkg;

    localparam int unsigned VEC_W    = 7;
    localparam int unsigned NUM_VEC  = 128;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SETTLE_W = 4;

    // Bit position of each datapath drive within the vector index
    localparam int unsigned BIT_A0 = 0;
    localparam int unsigned BIT_A1 = 1;
    localparam int unsigned BIT_B0 = 2;
    localparam int unsigned BIT_B1 = 3;
    localparam int unsigned BIT_SA = 4;
    localparam int unsigned BIT_SB = 5;
    localparam int unsigned BIT_SS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/adder_mux_ref.sv
// Combinational golden model of the 1-bit adder with operand and output muxes.
module adder_mux_ref
    import adder_mux_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_s0_c,
    output logic             exp_s1_c
);

    logic op_a;
    logic op_b;
    logic sum;
    logic carry;

    always_comb begin
        op_a  = vec[BIT_SA] ? vec[BIT_A1] : vec[BIT_A0];
        op_b  = vec[BIT_SB] ? vec[BIT_B1] : vec[BIT_B0];
        sum   = op_a ^ op_b;
        carry = op_a & op_b;
        // Ss selects which output carries the sum
        exp_s0_c = vec[BIT_SS] ? sum   : carry;
        exp_s1_c = vec[BIT_SS] ? carry : sum;
    end

endmodule

// File: rtl/adder_mux_bist.sv
// Exhaustive self-test sweep of the adder-mux datapath: drives all 128 input
// combinations, checks S0/S1 against the golden model and reports the results.
module adder_mux_bist
    import adder_mux_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             A0,
    output logic             A1,
    output logic             B0,
    output logic             B1,
    output logic             Sa,
    output logic             Sb,
    output logic             Ss,
    input  logic             S0,
    input  logic             S1,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail
);

    state_t              state;
    logic [VEC_W-1:0]    vec;
    logic [VEC_W-1:0]    drv;
    logic [SETTLE_W-1:0] wait_cnt;
    logic                exp_s0_c;
    logic                exp_s1_c;

    adder_mux_ref u_ref (
        .vec      (vec),
        .exp_s0_c (exp_s0_c),
        .exp_s1_c (exp_s1_c)
    );

    assign A0 = drv[BIT_A0];
    assign A1 = drv[BIT_A1];
    assign B0 = drv[BIT_B0];
    assign B1 = drv[BIT_B1];
    assign Sa = drv[BIT_SA];
    assign Sb = drv[BIT_SB];
    assign Ss = drv[BIT_SS];

    // done is never set while busy, so pass cannot assert mid-sweep
    assign pass = done & (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= '0;
            drv        <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        vec        <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    drv      <= vec;
                    wait_cnt <= '0;
                    state    <= (SETTLE == 0) ? ST_CHECK : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == SETTLE_W'(SETTLE - 1)) begin
                        state <= ST_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + SETTLE_W'(1);
                    end
                end
                ST_CHECK: begin
                    if ({S1, S0} != {exp_s1_c, exp_s0_c}) begin
                        err_count <= err_count + CNT_W'(1);
                        if (err_count == '0) begin
                            first_fail <= vec;
                        end
                    end
                    if (vec == VEC_W'(NUM_VEC - 1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec   <= vec + VEC_W'(1);
                        state <= ST_APPLY;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_mux_bist.sv
// Directed and randomized fault-injection sweeps of adder_mux_bist against an arithmetic reference.
module tb_adder_mux_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       a0, a1, b0, b1, sa, sb, ss, s0, s1;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [6:0] first_fail;

    logic       z_a0, z_a1, z_b0, z_b1, z_sa, z_sb, z_ss, z_s0, z_s1;
    logic       z_busy, z_done, z_pass;
    logic [7:0] z_err_count;
    logic [6:0] z_first_fail;

    int           checks = 0;
    int           errors = 0;
    int           mode   = 0;
    logic [127:0] flip0  = '0;
    logic [127:0] flip1  = '0;

    always #5 clk = ~clk;

    adder_mux_bist #(.SETTLE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A0(a0), .A1(a1), .B0(b0), .B1(b1), .Sa(sa), .Sb(sb), .Ss(ss),
        .S0(s0), .S1(s1),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail)
    );

    adder_mux_bist #(.SETTLE(0)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .start(start),
        .A0(z_a0), .A1(z_a1), .B0(z_b0), .B1(z_b1), .Sa(z_sa), .Sb(z_sb), .Ss(z_ss),
        .S0(z_s0), .S1(z_s1),
        .busy(z_busy), .done(z_done), .pass(z_pass),
        .err_count(z_err_count), .first_fail(z_first_fail)
    );

    // Reference datapath: operands added as integers, {S1,S0} returned
    function automatic logic [1:0] golden(input logic [6:0] v);
        int op_a, op_b, total;
        op_a  = v[4] ? int'(v[1]) : int'(v[0]);
        op_b  = v[5] ? int'(v[3]) : int'(v[2]);
        total = op_a + op_b;
        if (v[6]) return {total[1], total[0]};
        else      return {total[0], total[1]};
    endfunction

    logic [6:0] dv;
    logic [1:0] g;
    always_comb begin
        dv = {ss, sb, sa, b1, b0, a1, a0};
        g  = golden(dv);
        s0 = g[0];
        s1 = g[1];
        case (mode)
            1: s0 = 1'b0;
            2: s1 = 1'b0;
            3: begin s0 = g[1]; s1 = g[0]; end
            4: begin s0 = g[0] ^ flip0[dv]; s1 = g[1] ^ flip1[dv]; end
            default: ;
        endcase
    end

    logic [1:0] zg;
    always_comb begin
        zg   = golden({z_ss, z_sb, z_sa, z_b1, z_b0, z_a1, z_a0});
        z_s0 = zg[0];
        z_s1 = zg[1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input int mid_cyc, output int lat, output int lat_fast,
                             output logic busy_dn, output logic pass_busy);
        lat       = -1;
        lat_fast  = -1;
        busy_dn   = 1'bx;
        pass_busy = 1'b0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_cleared_on_start", 32'(done), 32'd0);
        check("err_cleared_on_start", 32'(err_count), 32'd0);
        for (int c = 1; c <= 2000; c++) begin
            @(posedge clk);
            #1;
            start = (c == mid_cyc);
            if ((busy && pass) || (z_busy && z_pass)) pass_busy = 1'b1;
            if (done && lat < 0) begin
                lat     = c;
                busy_dn = busy;
            end
            if (z_done && lat_fast < 0) lat_fast = c;
            if (lat >= 0 && lat_fast >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic sweep_and_check(input string tag, input int mid_cyc, input int exp_err,
                                   input int exp_ff);
        int   lat, lat_fast;
        logic busy_dn, pass_busy;
        run_sweep(mid_cyc, lat, lat_fast, busy_dn, pass_busy);
        check({tag, "_latency"}, 32'(lat), 32'd512);
        check({tag, "_fast_latency"}, 32'(lat_fast), 32'd256);
        check({tag, "_busy_at_done"}, 32'(busy_dn), 32'd0);
        check({tag, "_pass_while_busy"}, 32'(pass_busy), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        check({tag, "_first_fail"}, 32'(first_fail), 32'(exp_ff));
        check({tag, "_pass"}, 32'(pass), 32'(exp_err == 0));
        check({tag, "_drive_hold"}, 32'({ss, sb, sa, b1, b0, a1, a0}), 32'h7f);
        check({tag, "_fast_pass"}, 32'(z_pass), 32'd1);
    endtask

    initial begin
        int exp_err, exp_ff;
        rst_n = 1'b0;
        start = 1'b0;
        #3;
        check("reset_outputs", 32'({busy, done, pass, err_count, first_fail}), 32'd0);
        check("reset_drives", 32'({ss, sb, sa, b1, b0, a1, a0}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        mode = 0; sweep_and_check("good", 0, 0, 0);
        mode = 1; sweep_and_check("s0_sa0", 0, 48, 5);
        mode = 2; sweep_and_check("s1_sa0", 0, 48, 1);
        mode = 3; sweep_and_check("swap", 0, 96, 1);
        mode = 0; sweep_and_check("restart_ignored", 100, 0, 0);

        // Random per-vector output corruption, expected results counted directly
        for (int r = 0; r < 3; r++) begin
            exp_err = 0;
            exp_ff  = -1;
            for (int v = 0; v < 128; v++) begin
                flip0[v] = ($urandom_range(0, 15) == 0);
                flip1[v] = ($urandom_range(0, 15) == 0);
                if (flip0[v] || flip1[v]) begin
                    exp_err++;
                    if (exp_ff < 0) exp_ff = v;
                end
            end
            if (exp_ff < 0) exp_ff = 0;
            mode = 4;
            sweep_and_check($sformatf("random%0d", r), 0, exp_err, exp_ff);
        end

        // Reset part-way through a failing sweep, then a clean sweep
        mode = 1;
        pulse_start();
        repeat (200) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({busy, done, pass, err_count, first_fail}), 32'd0);
        check("midreset_drives", 32'({ss, sb, sa, b1, b0, a1, a0}), 32'd0);
        check("midreset_fast", 32'({z_busy, z_done, z_err_count}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        sweep_and_check("after_reset", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
